// File: rtl/l2_port_scheduler_if.sv
// Bundle of the requester-side and L2-side signals of the L2 port scheduler.
// master: the scheduler's view; slave: the environment (requesters and L2).
interface l2_port_scheduler_if;
    // Requester side
    logic         i_read;
    logic [15:0]  i_address;
    logic         d_read;
    logic         d_write;
    logic [15:0]  d_address;
    logic [127:0] d_wdata;
    logic         p_read;
    logic [15:0]  p_address;
    logic         i_resp;
    logic         d_resp;
    logic         p_resp;
    logic [127:0] rdata;
    // L2 side
    logic         l2_mem_read;
    logic         l2_mem_write;
    logic [15:0]  l2_mem_address;
    logic [127:0] l2_mem_wdata;
    logic         l2_mem_resp;
    logic [127:0] l2_mem_rdata;

    modport master (
        input  i_read, i_address, d_read, d_write, d_address, d_wdata,
               p_read, p_address, l2_mem_resp, l2_mem_rdata,
        output i_resp, d_resp, p_resp, rdata,
               l2_mem_read, l2_mem_write, l2_mem_address, l2_mem_wdata
    );

    modport slave (
        output i_read, i_address, d_read, d_write, d_address, d_wdata,
               p_read, p_address, l2_mem_resp, l2_mem_rdata,
        input  i_resp, d_resp, p_resp, rdata,
               l2_mem_read, l2_mem_write, l2_mem_address, l2_mem_wdata
    );
endinterface

// File: rtl/l2_port_scheduler.sv
// Shares one L2 line port between I-cache (0), D-side (1) and prefetcher (2).
// I/D are round-robin; prefetch is lowest priority with a starvation override.
module l2_port_scheduler #(
    parameter int unsigned STARVE_LIMIT = 16,
    parameter int unsigned STARVE_W     = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    l2_port_scheduler_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

    state_t                state_q, state_d;
    logic                  rr_last_q, rr_last_d;
    logic [STARVE_W-1:0]   starve_q, starve_d;
    logic [1:0]            owner_q, owner_d;
    logic                  write_q, write_d;
    logic [15:0]           addr_q, addr_d;
    logic [127:0]          wdata_q, wdata_d;
    logic [127:0]          rdata_q, rdata_d;

    logic                  d_req;
    logic                  grant_vld;
    logic [1:0]            grant_id;

    assign d_req = bus.d_read | bus.d_write;

    // Arbitration among pending requests; only acted upon in IDLE
    always_comb begin
        grant_vld = 1'b1;
        grant_id  = 2'd0;
        if (starve_q == LIMIT && bus.p_read) begin
            grant_id = 2'd2;
        end else if (bus.i_read && d_req) begin
            grant_id = rr_last_q ? 2'd0 : 2'd1;
        end else if (bus.i_read) begin
            grant_id = 2'd0;
        end else if (d_req) begin
            grant_id = 2'd1;
        end else if (bus.p_read) begin
            grant_id = 2'd2;
        end else begin
            grant_vld = 1'b0;
        end
    end

    // State and latched-request registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rr_last_q <= 1'b1;
            starve_q  <= '0;
            owner_q   <= '0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
            starve_q  <= starve_d;
            owner_q   <= owner_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
        end
    end

    // Next-state: FSM transitions, grant latching, starvation count, read capture
    always_comb begin
        state_d   = state_q;
        rr_last_d = rr_last_q;
        owner_d   = owner_q;
        write_d   = write_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;

        unique case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    state_d = BUSY;
                    owner_d = grant_id;
                    wdata_d = bus.d_wdata;
                    write_d = 1'b0;
                    unique case (grant_id)
                        2'd0: begin
                            addr_d    = bus.i_address;
                            rr_last_d = 1'b0;
                        end
                        2'd1: begin
                            addr_d    = bus.d_address;
                            // A simultaneous read is dropped; write takes the slot
                            write_d   = bus.d_write;
                            rr_last_d = 1'b1;
                        end
                        default: addr_d = bus.p_address;
                    endcase
                end
            end
            BUSY: begin
                if (bus.l2_mem_resp) begin
                    state_d = DONE;
                    rdata_d = bus.l2_mem_rdata;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Counts waiting cycles of a pending prefetch, saturating at the limit
        if (!bus.p_read || (state_q == IDLE && grant_vld && grant_id == 2'd2)) begin
            starve_d = '0;
        end else if (starve_q != LIMIT) begin
            starve_d = starve_q + 1'b1;
        end else begin
            starve_d = starve_q;
        end
    end

    // Outputs decoded from state so strobes fall with the async reset
    always_comb begin
        bus.l2_mem_read    = 1'b0;
        bus.l2_mem_write   = 1'b0;
        bus.l2_mem_address = '0;
        bus.l2_mem_wdata   = '0;
        bus.i_resp         = 1'b0;
        bus.d_resp         = 1'b0;
        bus.p_resp         = 1'b0;
        bus.rdata          = rdata_q;
        if (state_q == BUSY) begin
            bus.l2_mem_read    = ~write_q;
            bus.l2_mem_write   = write_q;
            bus.l2_mem_address = addr_q;
            bus.l2_mem_wdata   = write_q ? wdata_q : '0;
        end
        if (state_q == DONE) begin
            bus.i_resp = (owner_q == 2'd0);
            bus.d_resp = (owner_q == 2'd1);
            bus.p_resp = (owner_q == 2'd2);
        end
    end

endmodule

// File: tb/tb_l2_port_scheduler.sv
// Scoreboard bench for l2_port_scheduler: expected responses and L2 operations
// are queued at stimulus time and checked by independent monitors.
module tb_l2_port_scheduler;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    l2_port_scheduler_if bus();

    l2_port_scheduler #(.STARVE_LIMIT(16), .STARVE_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0]   owner;
        logic [127:0] data;
    } resp_t;

    typedef struct {
        logic         wr;
        logic [15:0]  addr;
        logic [127:0] wdata;
    } op_t;

    localparam logic [127:0] JUNK = {4{32'hDEADBEEF}};

    resp_t rq[$];
    op_t   oq[$];
    op_t   cur_op;

    int pass_cnt = 0;
    int total_cnt = 0;

    // requester bookkeeping: main adds to *_tot, driver advances *_done
    int i_tot = 0, d_tot = 0, p_tot = 0;
    int i_done = 0, d_done = 0, p_done = 0;
    bit d_rd = 1'b1, d_wr = 1'b0;

    // L2 model knobs
    int           lat = 1;
    bit           fixed_en = 1'b0;
    logic [127:0] fixed_data = '0;
    bit           hold_extra = 1'b0;
    bit           spur = 1'b0;
    int           l2_cnt = 0;
    bit           extra = 1'b0;

    // monitor counters
    int   rd_cycles = 0;
    int   wr_cycles = 0;
    logic prev_strobe = 1'b0;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // requester level drivers
    always @(negedge clk) begin
        if (!rst_n) begin
            i_done = i_tot; d_done = d_tot; p_done = p_tot;
        end else begin
            if (bus.i_resp && i_done < i_tot) i_done++;
            if (bus.d_resp && d_done < d_tot) d_done++;
            if (bus.p_resp && p_done < p_tot) p_done++;
        end
        bus.i_read  = (i_done < i_tot);
        bus.d_read  = (d_done < d_tot) && d_rd;
        bus.d_write = (d_done < d_tot) && d_wr;
        bus.p_read  = (p_done < p_tot);
    end

    // L2 model: answers after lat strobe cycles
    always @(negedge clk) begin
        if (!rst_n) begin
            l2_cnt = 0; extra = 1'b0;
            bus.l2_mem_resp = 1'b0; bus.l2_mem_rdata = JUNK;
        end else if (bus.l2_mem_read || bus.l2_mem_write) begin
            l2_cnt++;
            if (l2_cnt >= lat) begin
                bus.l2_mem_resp  = 1'b1;
                bus.l2_mem_rdata = fixed_en ? fixed_data : {8{bus.l2_mem_address}};
                extra = hold_extra;
            end else begin
                bus.l2_mem_resp  = 1'b0;
                bus.l2_mem_rdata = JUNK;
            end
        end else begin
            l2_cnt = 0;
            bus.l2_mem_rdata = JUNK;
            if (extra) begin
                bus.l2_mem_resp = 1'b1;
                extra = 1'b0;
            end else begin
                bus.l2_mem_resp = spur;
            end
        end
    end

    // monitor: response scoreboard and L2 operation scoreboard
    always @(negedge clk) begin
        logic [2:0] r;
        logic       strobe;
        resp_t      e;
        r = {bus.p_resp, bus.d_resp, bus.i_resp};
        if (r != 3'b000) begin
            if (rq.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_resp: got resp=%b expected none", r);
            end else begin
                e = rq.pop_front();
                check("resp_owner", {125'd0, r}, {125'd0, 3'b001 << e.owner});
                check("resp_rdata", bus.rdata, e.data);
            end
        end
        strobe = bus.l2_mem_read | bus.l2_mem_write;
        if (bus.l2_mem_read && bus.l2_mem_write) begin
            total_cnt++;
            $display("FAIL both_strobes: got rd=1 wr=1 expected one");
        end
        if (strobe) begin
            if (bus.l2_mem_read) rd_cycles++;
            if (bus.l2_mem_write) wr_cycles++;
            if (!prev_strobe) begin
                if (oq.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_l2_op: got addr=%0h expected none", bus.l2_mem_address);
                    cur_op.wr = bus.l2_mem_write;
                    cur_op.addr = bus.l2_mem_address;
                    cur_op.wdata = bus.l2_mem_wdata;
                end else begin
                    cur_op = oq.pop_front();
                    check("l2_op_write", {127'd0, bus.l2_mem_write}, {127'd0, cur_op.wr});
                end
            end
            check("l2_addr", {112'd0, bus.l2_mem_address}, {112'd0, cur_op.addr});
            if (cur_op.wr) check("l2_wdata", bus.l2_mem_wdata, cur_op.wdata);
        end
        prev_strobe = strobe;
    end

    task automatic push_txn(input logic [1:0] owner, input logic wr, input logic [15:0] addr,
                            input logic [127:0] wdata, input logic [127:0] data);
        resp_t r;
        op_t   o;
        o.wr = wr; o.addr = addr; o.wdata = wdata;
        oq.push_back(o);
        r.owner = owner; r.data = data;
        rq.push_back(r);
    endtask

    task automatic wait_done(input string nm, input int budget);
        int n;
        n = 0;
        while ((rq.size() != 0 || oq.size() != 0 || i_done < i_tot || d_done < d_tot || p_done < p_tot)
               && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            total_cnt++;
            $display("FAIL %s_timeout: got pending=%0d expected 0", nm, rq.size());
            rq.delete(); oq.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic check_idle_outputs(input string nm);
        check({nm, "_i_resp"}, {127'd0, bus.i_resp}, 128'd0);
        check({nm, "_d_resp"}, {127'd0, bus.d_resp}, 128'd0);
        check({nm, "_p_resp"}, {127'd0, bus.p_resp}, 128'd0);
        check({nm, "_rd"}, {127'd0, bus.l2_mem_read}, 128'd0);
        check({nm, "_wr"}, {127'd0, bus.l2_mem_write}, 128'd0);
        check({nm, "_addr"}, {112'd0, bus.l2_mem_address}, 128'd0);
    endtask

    initial begin
        int n, rd0, wr0;
        bus.i_address = '0; bus.d_address = '0; bus.p_address = '0; bus.d_wdata = '0;
        bus.i_read = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0; bus.p_read = 1'b0;
        bus.l2_mem_resp = 1'b0; bus.l2_mem_rdata = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        check("reset_rdata", bus.rdata, 128'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // single I read at 0x1230, L2 answers after 4 cycles; address changes mid-flight
        lat = 4; fixed_en = 1'b1; fixed_data = {16{8'hA5}};
        bus.i_address = 16'h1230;
        rd0 = rd_cycles;
        push_txn(2'd0, 1'b0, 16'h1230, '0, {16{8'hA5}});
        i_tot += 1;
        n = 0;
        while (!bus.l2_mem_read && n < 20) begin @(negedge clk); n++; end
        @(negedge clk); #1;
        bus.i_address = 16'hFFFF;
        wait_done("i_read", 50);
        check("i_read_cycles", 128'(rd_cycles - rd0), 128'd4);
        check("i_read_rdata_kept", bus.rdata, {16{8'hA5}});
        fixed_en = 1'b0;

        // I/D tie from reset alternates, I first
        do_reset();
        check_idle_outputs("reset2");
        check("reset2_rdata", bus.rdata, 128'd0);
        lat = 2;
        bus.i_address = 16'h1111; bus.d_address = 16'h2222; bus.p_address = 16'h3333;
        d_rd = 1'b1; d_wr = 1'b0;
        push_txn(2'd0, 1'b0, 16'h1111, '0, {8{16'h1111}});
        push_txn(2'd1, 1'b0, 16'h2222, '0, {8{16'h2222}});
        push_txn(2'd0, 1'b0, 16'h1111, '0, {8{16'h1111}});
        push_txn(2'd1, 1'b0, 16'h2222, '0, {8{16'h2222}});
        i_tot += 2; d_tot += 2;
        wait_done("rr", 100);

        // D read+write together: only the write goes out
        lat = 1;
        d_rd = 1'b1; d_wr = 1'b1;
        bus.d_address = 16'h4000; bus.d_wdata = 128'h1;
        rd0 = rd_cycles; wr0 = wr_cycles;
        push_txn(2'd1, 1'b1, 16'h4000, 128'h1, {8{16'h4000}});
        d_tot += 1;
        wait_done("rw", 50);
        check("rw_wr_cycles", 128'(wr_cycles - wr0), 128'd1);
        check("rw_rd_cycles", 128'(rd_cycles - rd0), 128'd0);
        d_wr = 1'b0;

        // prefetch starvation: forced grant after 16 waiting cycles
        do_reset();
        lat = 1;
        bus.i_address = 16'h1111; bus.d_address = 16'h2222; bus.p_address = 16'h3333;
        d_rd = 1'b1; d_wr = 1'b0;
        push_txn(2'd0, 1'b0, 16'h1111, '0, {8{16'h1111}});
        push_txn(2'd1, 1'b0, 16'h2222, '0, {8{16'h2222}});
        push_txn(2'd0, 1'b0, 16'h1111, '0, {8{16'h1111}});
        push_txn(2'd1, 1'b0, 16'h2222, '0, {8{16'h2222}});
        push_txn(2'd0, 1'b0, 16'h1111, '0, {8{16'h1111}});
        push_txn(2'd1, 1'b0, 16'h2222, '0, {8{16'h2222}});
        push_txn(2'd2, 1'b0, 16'h3333, '0, {8{16'h3333}});
        push_txn(2'd0, 1'b0, 16'h1111, '0, {8{16'h1111}});
        i_tot += 4; d_tot += 3; p_tot += 1;
        wait_done("starve", 200);

        // spurious L2 resp in IDLE
        @(posedge clk); #1;
        rd0 = rd_cycles; wr0 = wr_cycles;
        spur = 1'b1;
        @(posedge clk); #1;
        spur = 1'b0;
        repeat (4) @(negedge clk);
        check("spur_idle_strobes", 128'(rd_cycles - rd0 + wr_cycles - wr0), 128'd0);
        check("spur_idle_rdata", bus.rdata, {8{16'h1111}});
        check_idle_outputs("spur_idle");

        // spurious L2 resp in DONE (resp held one extra cycle)
        @(posedge clk); #1;
        hold_extra = 1'b1;
        push_txn(2'd0, 1'b0, 16'h1111, '0, {8{16'h1111}});
        i_tot += 1;
        wait_done("spur_done", 50);
        hold_extra = 1'b0;
        repeat (3) @(negedge clk);
        check("spur_done_rdata", bus.rdata, {8{16'h1111}});
        check_idle_outputs("spur_done");

        // reset during the 2nd BUSY cycle of a D write
        @(posedge clk); #1;
        lat = 10;
        d_rd = 1'b0; d_wr = 1'b1;
        bus.d_address = 16'h5000; bus.d_wdata = {4{32'h12345678}};
        begin
            op_t o;
            o.wr = 1'b1; o.addr = 16'h5000; o.wdata = {4{32'h12345678}};
            oq.push_back(o);
        end
        d_tot += 1;
        n = 0;
        wr0 = 0;
        while (wr0 < 2 && n < 30) begin
            @(negedge clk);
            if (bus.l2_mem_write) wr0++;
            n++;
        end
        check("abort_reached_busy2", 128'(wr0), 128'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_wr_drop", {127'd0, bus.l2_mem_write}, 128'd0);
        check("abort_rd_drop", {127'd0, bus.l2_mem_read}, 128'd0);
        repeat (2) @(negedge clk);
        check_idle_outputs("abort_reset");
        check("abort_rdata", bus.rdata, 128'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        lat = 1;
        d_rd = 1'b1; d_wr = 1'b0;
        bus.i_address = 16'h6666; bus.d_address = 16'h7777;
        push_txn(2'd0, 1'b0, 16'h6666, '0, {8{16'h6666}});
        push_txn(2'd1, 1'b0, 16'h7777, '0, {8{16'h7777}});
        i_tot += 1; d_tot += 1;
        wait_done("post_abort", 50);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
